// File: rtl/tx_pkt_loader.sv
// Write-side loader for the TX packet BRAM: streams words in,
// then hands the packet to dot11_tx via phy_tx_start/started/done.
module tx_pkt_loader #(
  parameter int ADDR_W        = 10,
  parameter int BASE_ADDR     = 0,
  parameter int MAX_WORDS     = 200,
  parameter int START_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [63:0]       bram_dout,
  output logic              phy_tx_start,
  input  logic              phy_tx_started,
  input  logic              phy_tx_done,
  output logic              busy,
  output logic [ADDR_W:0]   pkt_words,
  output logic              err_overflow,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DROP, START, WAIT_DONE
  } state_e;

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAXW = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [TW-1:0]     TLST = TW'(START_TIMEOUT - 1);

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [TW-1:0]     tmo_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [63:0]       dout_q;
  logic              start_q;
  logic [ADDR_W:0]   words_q;
  logic              ovf_q;
  logic              tmo_err_q;
  logic              accept;
  logic              fire;

  assign accept = (state_q == IDLE) ||
                  (state_q == LOAD) ||
                  (state_q == DROP);
  // Gated by rst so no word can slip in during the reset cycle.
  assign s_ready      = ~rst & accept;
  assign fire         = s_valid & s_ready;
  assign bram_we      = we_q;
  assign bram_waddr   = waddr_q;
  assign bram_dout    = dout_q;
  assign phy_tx_start = start_q;
  assign busy         = (state_q != IDLE);
  assign pkt_words    = words_q;
  assign err_overflow = ovf_q;
  assign err_timeout  = tmo_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      dout_q    <= '0;
      start_q   <= 1'b0;
      words_q   <= '0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tmo_q <= '0;
          if (fire) begin
            we_q    <= 1'b1;
            waddr_q <= BASE;
            dout_q  <= s_data;
            cnt_q   <= (ADDR_W+1)'(1);
            if (s_last) begin
              words_q <= (ADDR_W+1)'(1);
              start_q <= 1'b1;
              state_q <= START;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (fire) begin
            // cnt_q == MAXW means this is the first word past the limit.
            if (cnt_q == MAXW) begin
              ovf_q   <= 1'b1;
              state_q <= s_last ? IDLE : DROP;
            end else begin
              we_q    <= 1'b1;
              waddr_q <= BASE + cnt_q[ADDR_W-1:0];
              dout_q  <= s_data;
              cnt_q   <= cnt_q + 1'b1;
              if (s_last) begin
                words_q <= cnt_q + 1'b1;
                start_q <= 1'b1;
                state_q <= START;
              end
            end
          end
        end
        DROP: begin
          if (fire && s_last) state_q <= IDLE;
        end
        START: begin
          if (phy_tx_started) begin
            start_q <= 1'b0;
            state_q <= WAIT_DONE;
          end else if (tmo_q == TLST) begin
            start_q   <= 1'b0;
            tmo_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (phy_tx_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pkt_loader.sv
// Bench for tx_pkt_loader: packet-level write scoreboard plus
// directed checks on start/timeout/overflow/reset behaviour.
module tb_tx_pkt_loader;

  localparam int AW   = 10;
  localparam int BASE = 0;
  localparam int MAXW = 200;
  localparam int TMO  = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [63:0]   bram_dout;
  logic          phy_tx_start;
  logic          phy_tx_started;
  logic          phy_tx_done;
  logic          busy;
  logic [AW:0]   pkt_words;
  logic          err_overflow;
  logic          err_timeout;

  tx_pkt_loader #(
    .ADDR_W(AW), .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW), .START_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready),
    .bram_we(bram_we), .bram_waddr(bram_waddr),
    .bram_dout(bram_dout),
    .phy_tx_start(phy_tx_start),
    .phy_tx_started(phy_tx_started),
    .phy_tx_done(phy_tx_done),
    .busy(busy), .pkt_words(pkt_words),
    .err_overflow(err_overflow),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int  nvec = 0;
  int  fail = 0;
  int  cyc = 0;
  int  pkt_id = 0;
  int  start_hi = 0;
  int  ovf_cnt = 0;
  int  ovf_cyc = -1;
  int  tmo_cnt = 0;
  int  tmo_cyc = -1;
  int  last_xfer = 0;
  int  ovf_xfer = -1;
  int  stalls = 0;
  wr_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] data_of(input int p, input int i);
    return {16'(p), 16'hC0DE, 32'(i * 7 + 3)};
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  // Scoreboard: every BRAM write must match the next predicted one.
  always @(negedge clk) begin
    if (bram_we) begin
      nvec++;
      if (exp_q.size() == 0) begin
        fail++;
        $display("FAIL bram_write: unexpected addr %0d data %h",
                 bram_waddr, bram_dout);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bram_waddr !== e.addr || bram_dout !== e.data) begin
          fail++;
          $display("FAIL bram_write: got %0d/%h want %0d/%h",
                   bram_waddr, bram_dout, e.addr, e.data);
        end
      end
    end
    if (phy_tx_start) start_hi++;
    if (err_overflow) begin ovf_cnt++; ovf_cyc = cyc; end
    if (err_timeout) begin tmo_cnt++; tmo_cyc = cyc; end
  end

  // Called at posedge+1; returns at posedge+1 after the final transfer.
  task automatic send_pkt(input int n, input bit last, input bit gaps);
    int w;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 0) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = data_of(pkt_id, i);
      s_last  = last && (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!s_ready && w < 1000) begin
        w++; stalls++;
        @(negedge clk);
      end
      if (!s_ready) begin
        check("handshake_timeout", 64'(w), 64'(0));
        s_valid = 1'b0;
        return;
      end
      last_xfer = cyc;
      if (i == MAXW) ovf_xfer = cyc;
      if (i < MAXW)
        exp_q.push_back('{AW'(BASE + i), data_of(pkt_id, i)});
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Entered in the first cycle phy_tx_start should be high.
  task automatic finish_tx(input int sdly, input int ddly);
    int rdy;
    rdy = 0;
    start_hi = 0;
    for (int k = 0; k < sdly; k++) begin
      @(negedge clk);
      if (k == 0) check("start_rise", 64'(phy_tx_start), 64'(1));
      if (s_ready) rdy++;
      @(posedge clk); #1;
    end
    phy_tx_started = 1'b1;
    @(negedge clk);
    if (s_ready) rdy++;
    @(posedge clk); #1;
    phy_tx_started = 1'b0;
    for (int k = 0; k < ddly - 1; k++) begin
      @(negedge clk);
      if (s_ready) rdy++;
      @(posedge clk); #1;
    end
    phy_tx_done = 1'b1;
    @(negedge clk);
    if (s_ready) rdy++;
    @(posedge clk); #1;
    phy_tx_done = 1'b0;
    @(negedge clk);
    check("start_len", 64'(start_hi), 64'(sdly + 1));
    check("ready_while_tx", 64'(rdy), 64'(0));
    check("ready_after_done", 64'(s_ready), 64'(1));
    check("busy_after_done", 64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;
    phy_tx_started = 1'b0;
    phy_tx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_bram_we", 64'(bram_we), 64'(0));
    check("rst_waddr", 64'(bram_waddr), 64'(0));
    check("rst_dout", bram_dout, 64'(0));
    check("rst_start", 64'(phy_tx_start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pkt_words", 64'(pkt_words), 64'(0));
    check("rst_errs", 64'({err_overflow, err_timeout}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk); #1;

    // 200 words at full rate, exactly MAX_WORDS
    pkt_id = 1;
    send_pkt(200, 1'b1, 1'b0);
    check("full_rate_stalls", 64'(stalls), 64'(0));
    finish_tx(1, 3);
    check("pkt200_words", 64'(pkt_words), 64'(200));
    check("pkt200_drained", 64'(exp_q.size()), 64'(0));

    // 3 words, started 5 cycles late, done 100 cycles after that
    pkt_id = 2;
    send_pkt(3, 1'b1, 1'b0);
    finish_tx(5, 100);
    check("pkt3_words", 64'(pkt_words), 64'(3));
    check("pkt3_drained", 64'(exp_q.size()), 64'(0));

    // 205 words: overflow on transfer 201, rest dropped
    pkt_id = 3;
    start_hi = 0;
    ovf_cnt = 0;
    send_pkt(205, 1'b1, 1'b0);
    @(negedge clk);
    check("ovf_busy", 64'(busy), 64'(0));
    check("ovf_s_ready", 64'(s_ready), 64'(1));
    check("ovf_stalls", 64'(stalls), 64'(0));
    repeat (10) @(negedge clk);
    check("ovf_no_start", 64'(start_hi), 64'(0));
    check("ovf_pulses", 64'(ovf_cnt), 64'(1));
    check("ovf_cycle", 64'(ovf_cyc), 64'(ovf_xfer + 1));
    check("ovf_pkt_words", 64'(pkt_words), 64'(3));
    check("ovf_drained", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;

    // start never acknowledged: timeout after 64 cycles
    pkt_id = 4;
    start_hi = 0;
    tmo_cnt = 0;
    send_pkt(5, 1'b1, 1'b0);
    repeat (70) begin @(posedge clk); #1; end
    @(negedge clk);
    check("tmo_start_len", 64'(start_hi), 64'(TMO));
    check("tmo_pulses", 64'(tmo_cnt), 64'(1));
    check("tmo_cycle", 64'(tmo_cyc), 64'(last_xfer + 1 + TMO));
    check("tmo_busy", 64'(busy), 64'(0));
    check("tmo_pkt_words", 64'(pkt_words), 64'(5));
    @(posedge clk); #1;

    // reset after 50 words of an unterminated packet
    pkt_id = 5;
    send_pkt(50, 1'b0, 1'b0);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = data_of(pkt_id, 50);
    @(negedge clk);
    check("rst_mid_ready", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_we", 64'(bram_we), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_words", 64'(pkt_words), 64'(0));
    check("rst_mid_drained", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
    pkt_id = 6;
    send_pkt(4, 1'b1, 1'b0);
    finish_tx(2, 5);
    check("pkt4_words", 64'(pkt_words), 64'(4));
    check("pkt4_drained", 64'(exp_q.size()), 64'(0));

    // 17 words with random valid gaps
    pkt_id = 7;
    send_pkt(17, 1'b1, 1'b1);
    finish_tx(3, 4);
    check("pkt17_words", 64'(pkt_words), 64'(17));
    check("pkt17_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, fail);
    $finish;
  end

endmodule

// File: doc/tx_pkt_loader.md
# tx_pkt_loader

Write-side companion of the transmit packet buffer. Accepts a packet as a stream of 64-bit words, writes it into the BRAM that `dot11_tx` reads via `bram_addr`/`bram_din`, then kicks `phy_tx_start` and holds off new packets until `phy_tx_done`. It sits between the host/DMA stream and the shared TX BRAM, in the `clk` domain of `dot11_tx`.

## Interface
- `ADDR_W`, 10: BRAM word-address width; must match `dot11_tx` `bram_addr`.
- `BASE_ADDR`, 0: first BRAM word written for every packet.
- `MAX_WORDS`, 200: maximum words per packet; must satisfy BASE_ADDR+MAX_WORDS ≤ 2^ADDR_W.
- `START_TIMEOUT`, 64: cycles to wait for `phy_tx_started` before aborting.

- `clk`  in  1  single clock (200 MHz domain of `dot11_tx`).
- `rst`  in  1  reset; synchronous, active-high.
- `s_data`  in  64  packet word (same layout `dot11_tx` expects on `bram_din`).
- `s_valid`  in  1  word valid.
- `s_last`  in  1  final word of packet; qualified by `s_valid`.
- `s_ready`  out  1  loader accepts a word this cycle.
- `bram_we`  out  1  BRAM write enable.
- `bram_waddr`  out  ADDR_W  BRAM write address.
- `bram_dout`  out  64  BRAM write data.
- `phy_tx_start`  out  1  start request to `dot11_tx`.
- `phy_tx_started`  in  1  `dot11_tx` has begun transmission.
- `phy_tx_done`  in  1  `dot11_tx` has finished.
- `busy`  out  1  high in any state other than IDLE.
- `pkt_words`  out  ADDR_W+1  word count of the last accepted packet.
- `err_overflow`  out  1  one-cycle pulse: packet exceeded MAX_WORDS.
- `err_timeout`  out  1  one-cycle pulse: `phy_tx_started` did not arrive.

## Operation
- States: IDLE, LOAD, DROP, START, WAIT_DONE.
- Handshake: a word transfers when `s_valid && s_ready`. `s_ready` is 1 in IDLE, LOAD and DROP, and 0 in START and WAIT_DONE.
- IDLE: word counter cnt=0. The first transfer writes to BASE_ADDR and goes to LOAD, or to START if `s_last` is set.
- LOAD: each transfer writes to BASE_ADDR+cnt, then cnt++.
  - Transfer with `s_last`: `pkt_words` ← cnt+1, go to START.
  - Transfer number MAX_WORDS+1 without a prior `s_last`: not written; pulse `err_overflow`, go to DROP. If that word carries `s_last`, go straight to IDLE instead.
- DROP: discard words, no writes, until a transfer with `s_last`, then go to IDLE. No transmission for the truncated packet; `pkt_words` is unchanged.
- START: `phy_tx_start`=1 and the timeout counter increments.
  - On `phy_tx_started`=1: drop `phy_tx_start` next cycle and go to WAIT_DONE.
  - After START_TIMEOUT cycles without it: pulse `err_timeout` and go to IDLE.
- WAIT_DONE: go to IDLE on `phy_tx_done`=1. If `phy_tx_started` and `phy_tx_done` are both 1 in START, `phy_tx_started` is honored first; `phy_tx_done` is then sampled in WAIT_DONE.
- BRAM contents are never cleared; only words 0..pkt_words-1 (offset from BASE_ADDR) are valid.
- Reset in any state: return to IDLE at once. A partial packet is abandoned and any in-flight write is suppressed (`bram_we` forced to 0 in the reset cycle).

## Timing
- Reset values: `s_ready`=0 during the reset cycle (1 from the first IDLE cycle); `bram_we`=0, `bram_waddr`=0, `bram_dout`=0, `phy_tx_start`=0, `busy`=0, `pkt_words`=0, `err_overflow`=0, `err_timeout`=0.
- BRAM write is registered: a transfer at cycle N gives `bram_we`=1 with address and data at cycle N+1.
- Last-word transfer at cycle N: last write at N+1, `phy_tx_start`=1 from N+1. The BRAM write lands before `dot11_tx` samples the start.
- `phy_tx_started` high at cycle M: `phy_tx_start`=0 from M+1.
- Back-to-back words at full rate: one per cycle, with no bubbles in LOAD or DROP.
- `busy` is registered with the state: 1 from the cycle after the first transfer until the cycle after IDLE is re-entered.

## Test plan
- 200-word packet with `s_valid` always 1 and `s_last` on word 199 → 200 writes at addresses 0..199 matching the input data; `pkt_words`=200; `phy_tx_start` rises one cycle after the last transfer.
- 3-word packet; `phy_tx_started` asserted 5 cycles after start and `phy_tx_done` 100 cycles later → `phy_tx_start` high exactly 6 cycles; `s_ready`=0 until the cycle after `phy_tx_done`.
- 205-word packet (MAX_WORDS=200) → 200 writes, `err_overflow` pulses on transfer 201, no writes for 201..205, `phy_tx_start` never asserts, back in IDLE after word 205.
- Valid packet with `phy_tx_started` held 0 → `phy_tx_start` high for 64 cycles, `err_timeout` pulses once, next packet accepted.
- `rst` asserted mid-LOAD at word 50 → next cycle `bram_we`=0 and `busy`=0. A following 4-word packet writes addresses 0..3 and starts normally.
- Random `s_valid` gaps (50% duty) on a 17-word packet → 17 writes at contiguous addresses with correct data, `pkt_words`=17.
